// File: rtl/lcd_time_writer.sv
// Refresh sequencer between the elapsed-time formatter and the character-LCD byte driver.
// Each refresh period it snapshots MM:SS and streams one cursor command plus five characters.
module lcd_time_writer #(
   parameter int unsigned REFRESH_TICKS  = 5000000,
   parameter logic [7:0]  CURSOR_ADDR    = 8'h80,
   parameter bit          SKIP_UNCHANGED = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [7:0] time_vec1,
   input  logic [7:0] time_vec2,
   input  logic [7:0] time_vec3,
   input  logic [7:0] time_vec4,
   input  logic [7:0] time_vec5,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_rs,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CMD, S_CHAR, S_DONE} state_t;

   localparam logic [26:0] LAST_COUNT = 27'(REFRESH_TICKS - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [26:0]     r_count;
   logic [4:0][7:0] r_snap;
   logic [4:0][7:0] r_last;
   logic [2:0]      r_idx;
   logic            r_first;
   logic [4:0][7:0] w_vec;
   logic            w_tick;
   logic            w_xfer;
   logic            w_same;

   assign w_vec  = {time_vec5, time_vec4, time_vec3, time_vec2, time_vec1};
   assign w_tick = enable && (r_count == LAST_COUNT);
   assign w_xfer = out_valid && out_ready;
   assign w_same = SKIP_UNCHANGED && !r_first && (w_vec == r_last);

   // Counter keeps running while a frame is in flight; ticks seen outside IDLE are simply lost.
   always_ff @(posedge clk) begin
      if (!reset_n || !enable) begin
         r_count <= '0;
      end else if (w_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 27'd1;
      end
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no branch leaves the signal unassigned and infers a latch.
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_tick) w_next_state = S_SNAP;
         S_SNAP:  w_next_state = w_same ? S_IDLE : S_CMD;
         S_CMD:   if (w_xfer) w_next_state = S_CHAR;
         S_CHAR:  if (w_xfer && (r_idx == 3'd4)) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid  = 1'b0;
      out_rs     = 1'b0;
      out_data   = '0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (r_state)
         S_SNAP: busy = 1'b1;
         S_CMD: begin
            out_valid = 1'b1;
            out_data  = CURSOR_ADDR;
            busy      = 1'b1;
         end
         S_CHAR: begin
            out_valid = 1'b1;
            out_rs    = 1'b1;
            out_data  = r_snap[r_idx];
            busy      = 1'b1;
         end
         S_DONE:  frame_done = 1'b1;
         default: ;
      endcase
   end

   // NOTE: the frame registers are reset too, because the skip compare must never see stale data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_snap  <= '0;
         r_last  <= '0;
         r_first <= 1'b1;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_SNAP: r_snap <= w_vec;
            S_CMD:  r_idx  <= '0;
            S_CHAR: if (w_xfer) r_idx <= r_idx + 3'd1;
            S_DONE: begin
               r_last  <= r_snap;
               r_first <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_time_writer.sv
// Self-checking bench for lcd_time_writer: a queue-based frame model checked every cycle,
// directed boundary scenarios pinned with literal byte sequences, then randomized traffic.
module tb_lcd_time_writer;

   localparam int         N   = 16;
   localparam logic [7:0] CMD = 8'h80;

   typedef logic [4:0][7:0] frame_t;
   typedef enum {M_IDLE, M_SNAP, M_SEND, M_DONE} mphase_t;

   logic       clk = 1'b0;
   logic       reset_n, enable, out_ready;
   logic       out_valid, out_rs, busy, frame_done;
   logic [7:0] out_data;
   frame_t     vec;

   always #5 clk = ~clk;

   lcd_time_writer #(
      .REFRESH_TICKS (N),
      .CURSOR_ADDR   (CMD),
      .SKIP_UNCHANGED(1'b1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .time_vec1 (vec[0]),
      .time_vec2 (vec[1]),
      .time_vec3 (vec[2]),
      .time_vec4 (vec[3]),
      .time_vec5 (vec[4]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rs    (out_rs),
      .busy      (busy),
      .frame_done(frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a frame is a queue of {rs,byte}; the refresh timer is plain modular arithmetic.
   mphase_t    m_phase = M_IDLE;
   int         m_cnt   = 0;
   logic [8:0] m_q[$];
   frame_t     m_last, m_frame;
   bit         m_first = 1'b1;
   bit         m_known = 1'b0;

   task automatic model_step();
      bit tick;
      if (!reset_n) begin
         m_known = 1'b1;
         m_cnt   = 0;
         m_phase = M_IDLE;
         m_q.delete();
         m_last  = '0;
         m_first = 1'b1;
         return;
      end
      tick  = enable && (m_cnt == N - 1);
      m_cnt = enable ? (m_cnt + 1) % N : 0;
      case (m_phase)
         M_IDLE: if (tick) m_phase = M_SNAP;
         M_SNAP: begin
            if (!m_first && vec == m_last) begin
               m_phase = M_IDLE;
            end else begin
               m_frame = vec;
               m_q.delete();
               m_q.push_back({1'b0, CMD});
               for (int i = 0; i < 5; i++) m_q.push_back({1'b1, vec[i]});
               m_phase = M_SEND;
            end
         end
         M_SEND: if (out_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = M_DONE;
         end
         default: begin
            m_last  = m_frame;
            m_first = 1'b0;
            m_phase = M_IDLE;
         end
      endcase
   endtask

   logic [8:0] dut_log[$];
   int         step_no = 0;
   int         fd_count = 0;
   int         fd_step = -1;
   int         busy_rise_step = -1;
   logic       p_hold = 1'b0;
   logic       p_busy = 1'b0;
   logic       p_rs;
   logic [7:0] p_data;

   // One cycle: compare at negedge, monitor, drive inputs for the next posedge, advance model.
   task automatic step(input logic rst_v, input logic en_v, input logic rdy_v, input frame_t v);
      @(negedge clk);
      step_no++;
      if (m_known) begin
         check("out_valid", out_valid, m_phase == M_SEND);
         check("busy", busy, (m_phase == M_SNAP) || (m_phase == M_SEND));
         check("frame_done", frame_done, m_phase == M_DONE);
         if (m_phase == M_SEND) check("byte", {out_rs, out_data}, m_q[0]);
         if (p_hold) begin
            check("stall valid", out_valid, 1'b1);
            check("stall byte", {out_rs, out_data}, {p_rs, p_data});
         end
      end
      if (busy && !p_busy) busy_rise_step = step_no;
      if (frame_done) begin
         fd_count++;
         fd_step = step_no;
      end
      reset_n   = rst_v;
      enable    = en_v;
      out_ready = rdy_v;
      vec       = v;
      if (rst_v && out_valid && rdy_v) dut_log.push_back({out_rs, out_data});
      p_hold = rst_v && out_valid && !rdy_v;
      p_rs   = out_rs;
      p_data = out_data;
      p_busy = busy;
      model_step();
   endtask

   function automatic frame_t mk(input string s);
      frame_t f;
      for (int i = 0; i < 5; i++) f[i] = s[i];
      return f;
   endfunction

   task automatic check_frame(input string name, input int base, input frame_t f);
      check({name, " count"}, dut_log.size() - base, 6);
      if (dut_log.size() >= base + 6) begin
         check({name, " cmd"}, dut_log[base], {1'b0, CMD});
         for (int i = 0; i < 5; i++)
            check($sformatf("%s char%0d", name, i), dut_log[base + 1 + i], {1'b1, f[i]});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      frame_t v23, v24, v0200, f_hex;
      frame_t pool[3];
      frame_t rv;
      int c0, base, fd_base;

      v23   = mk("01:23");
      v24   = mk("01:24");
      v0200 = mk("02:00");
      f_hex = {8'h33, 8'h32, 8'h3A, 8'h31, 8'h30};
      reset_n = 1'b0; enable = 1'b0; out_ready = 1'b1; vec = v23;

      repeat (3) step(1'b0, 1'b0, 1'b1, v23);
      check("reset out_valid", out_valid, 1'b0);
      check("reset out_data", out_data, 8'h00);
      check("reset out_rs", out_rs, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset frame_done", frame_done, 1'b0);

      // Basic frame: busy after tick+1, frame_done 8 cycles after the wrap.
      c0 = step_no + 1;
      base = dut_log.size();
      fd_base = fd_count;
      repeat (30) step(1'b1, 1'b1, 1'b1, v23);
      check_frame("t1", base, f_hex);
      check("t1 frames", fd_count - fd_base, 1);
      check("t1 busy rise", busy_rise_step, c0 + 16);
      check("t1 done step", fd_step, c0 + 23);

      // Unchanged frame is skipped; a changed seconds digit is sent.
      base = dut_log.size();
      fd_base = fd_count;
      repeat (16) step(1'b1, 1'b1, 1'b1, v23);
      check("t2 skip bytes", dut_log.size() - base, 0);
      check("t2 skip frames", fd_count - fd_base, 0);
      check("t2 snap busy", busy_rise_step, c0 + 32);
      base = dut_log.size();
      fd_base = fd_count;
      repeat (30) step(1'b1, 1'b1, 1'b1, v24);
      check_frame("t2 changed", base, v24);
      check("t2 frames", fd_count - fd_base, 1);

      // Inputs change mid-frame (at CHAR idx 2); the snapshot is what goes out.
      base = dut_log.size();
      fd_base = fd_count;
      for (int k = 0; k < 40 && fd_count == fd_base; k++)
         step(1'b1, 1'b1, 1'b1, (dut_log.size() - base >= 3) ? v24 : v23);
      check_frame("t4", base, f_hex);

      // Sparse out_ready: same byte sequence, held stable while stalled.
      base = dut_log.size();
      fd_base = fd_count;
      repeat (80) step(1'b1, 1'b1, ($urandom_range(0, 2) == 0), v24);
      check_frame("t3", base, v24);
      check("t3 frames", fd_count - fd_base, 1);

      // Long stall across three periods: exactly one frame after release.
      base = dut_log.size();
      fd_base = fd_count;
      repeat (3 * N + 4) step(1'b1, 1'b1, 1'b0, v0200);
      check("t5 stalled bytes", dut_log.size() - base, 0);
      repeat (30) step(1'b1, 1'b1, 1'b1, v0200);
      check_frame("t5", base, v0200);
      check("t5 frames", fd_count - fd_base, 1);

      // Reset during CHAR idx 3; first frame afterwards is sent although unchanged.
      base = dut_log.size();
      for (int k = 0; k < 40 && dut_log.size() - base < 4; k++) step(1'b1, 1'b1, 1'b1, v23);
      check("t6 reached idx3", dut_log.size() - base, 4);
      step(1'b0, 1'b1, 1'b1, v23);
      step(1'b1, 1'b1, 1'b1, v0200);
      check("t6 valid", out_valid, 1'b0);
      check("t6 data", out_data, 8'h00);
      check("t6 rs", out_rs, 1'b0);
      check("t6 busy", busy, 1'b0);
      base = dut_log.size();
      fd_base = fd_count;
      repeat (40) step(1'b1, 1'b1, 1'b1, v0200);
      check_frame("t6 after reset", base, v0200);
      check("t6 frames", fd_count - fd_base, 1);

      // Randomized traffic: enable drops, stalls, resets and input churn, all against the model.
      pool[0] = v23; pool[1] = v24; pool[2] = v0200;
      rv = v23;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 3) == 0)
               for (int i = 0; i < 5; i++) rv[i] = 8'h30 + 8'($urandom_range(0, 9));
            else
               rv = pool[$urandom_range(0, 2)];
         end
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 1) == 1), rv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
